// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//   VGA-style timing generator with built-in test patterns (colour bars,
//   checkerboard, gradient, solid colour). Horizontal and vertical counters
//   walk sync -> back porch -> active -> front porch; every output is a flop
//   fed from the current counter state, so all outputs share one clock of
//   latency and stay mutually aligned.
//
// Ports
//   clk          pixel clock
//   rst_n        synchronous active-low reset
//   mode         pattern select (0 bars, 1 checker, 2 gradient, 3 solid),
//                sampled only at counter position (0,0)
//   solid_color  colour word for solid mode, sampled with mode
//   hsync/vsync  sync pulses, active level set by HSYNC_POL / VSYNC_POL
//   de           active-video flag
//   r/g/b        colour, word mapped MSB-first onto {r,g,b}
//   pix_x/pix_y  active column / row (0 outside the active area)
//   frame_start  one-cycle pulse on the output cycle of position (0,0)
//   frame_cnt    completed-frame counter, wraps 255 -> 0
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 128,
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 32,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 14,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int RW         = 3,
    parameter int GW         = 3,
    parameter int BW         = 2,
    parameter int CHECK_LOG2 = 5,
    localparam int CW        = RW + GW + BW,
    localparam int XW        = $clog2(H_ACTIVE),
    localparam int YW        = $clog2(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] solid_color,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [RW-1:0] r,
    output logic [GW-1:0] g,
    output logic [BW-1:0] b,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_LO    = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_HI    = HW'(H_TOTAL - H_FP);
    localparam logic [HW-1:0] H_STEP_LAST = HW'(H_ACTIVE / 16 - 1);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_LO    = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_HI    = VW'(V_TOTAL - V_FP);
    localparam logic [VW-1:0] V_STEP_LAST = VW'(V_ACTIVE / 16 - 1);

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_GRAD  = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // Timing and pattern state
    logic [HW-1:0] hctr_q, hctr_d;
    logic [VW-1:0] vctr_q, vctr_d;
    logic [HW-1:0] hstep_q, hstep_d;
    logic [VW-1:0] vstep_q, vstep_d;
    logic [3:0]    hb_q, hb_d;
    logic [3:0]    vb_q, vb_d;
    mode_e         mode_q, mode_d;
    logic [CW-1:0] solid_q, solid_d;
    logic [7:0]    fcnt_q, fcnt_d;

    // Output registers
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic [CW-1:0] rgb_q, rgb_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [YW-1:0] pix_y_q, pix_y_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;

    // Combinational helpers
    logic          h_last, v_last, h_act, v_act, at_origin;
    logic [XW-1:0] x_w;
    logic [YW-1:0] y_w;
    logic [CW-1:0] word;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        hctr_d        = hctr_q;
        vctr_d        = vctr_q;
        hstep_d       = hstep_q;
        vstep_d       = vstep_q;
        hb_d          = hb_q;
        vb_d          = vb_q;
        mode_d        = mode_q;
        solid_d       = solid_q;
        fcnt_d        = fcnt_q;
        word          = '0;

        h_last    = (hctr_q == H_LAST);
        v_last    = (vctr_q == V_LAST);
        h_act     = (hctr_q >= H_ACT_LO) && (hctr_q < H_ACT_HI);
        v_act     = (vctr_q >= V_ACT_LO) && (vctr_q < V_ACT_HI);
        at_origin = (hctr_q == '0) && (vctr_q == '0);
        x_w       = XW'(hctr_q - H_ACT_LO);
        y_w       = YW'(vctr_q - V_ACT_LO);

        // Raster counters
        if (h_last) begin
            hctr_d = '0;
            vctr_d = v_last ? '0 : vctr_q + 1'b1;
        end else begin
            hctr_d = hctr_q + 1'b1;
        end
        if (h_last && v_last) begin
            fcnt_d = fcnt_q + 8'd1;
        end

        // Pattern controls are frozen for the whole frame
        if (at_origin) begin
            mode_d  = mode_e'(mode);
            solid_d = solid_color;
        end

        // Horizontal band: cleared on the last clock of every line so it is
        // zero when the next line begins; steps only across active pixels.
        if (h_last) begin
            hstep_d = '0;
            hb_d    = '0;
        end else if (h_act) begin
            if (hstep_q == H_STEP_LAST) begin
                hstep_d = '0;
                if (hb_q != 4'd15) hb_d = hb_q + 4'd1;
            end else begin
                hstep_d = hstep_q + 1'b1;
            end
        end

        // Vertical band: steps at the end of each active line, cleared at
        // the frame wrap.
        if (h_last && v_last) begin
            vstep_d = '0;
            vb_d    = '0;
        end else if (h_last && v_act) begin
            if (vstep_q == V_STEP_LAST) begin
                vstep_d = '0;
                if (vb_q != 4'd15) vb_d = vb_q + 4'd1;
            end else begin
                vstep_d = vstep_q + 1'b1;
            end
        end

        unique case (mode_q)
            MODE_BARS:  word = CW'({hb_q, vb_q});
            MODE_CHECK: word = (x_w[CHECK_LOG2] ^ y_w[CHECK_LOG2]) ? {CW{1'b1}} : '0;
            MODE_GRAD:  word = CW'(x_w) + CW'(y_w) + CW'(fcnt_q);
            MODE_SOLID: word = solid_q;
            default:    word = '0;
        endcase

        hsync_d       = (hctr_q < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
        vsync_d       = (vctr_q < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;
        de_d          = h_act && v_act;
        rgb_d         = de_d ? word : '0;
        pix_x_d       = de_d ? x_w : '0;
        pix_y_d       = de_d ? y_w : '0;
        frame_start_d = at_origin;
        frame_cnt_d   = fcnt_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of the others.
        if (!rst_n) begin
            hctr_q        <= '0;
            vctr_q        <= '0;
            hstep_q       <= '0;
            vstep_q       <= '0;
            hb_q          <= '0;
            vb_q          <= '0;
            mode_q        <= MODE_BARS;
            solid_q       <= '0;
            fcnt_q        <= '0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hctr_q        <= hctr_d;
            vctr_q        <= vctr_d;
            hstep_q       <= hstep_d;
            vstep_q       <= vstep_d;
            hb_q          <= hb_d;
            vb_q          <= vb_d;
            mode_q        <= mode_d;
            solid_q       <= solid_d;
            fcnt_q        <= fcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign {r, g, b}   = rgb_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen
//   Small-raster bench (H 4/4/32/4, V 2/2/16/1). The reference model turns a
//   cycle index since reset release into a raster position with division and
//   modulo, and computes the expected pixel from the pattern rules directly.
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;

    localparam int HS = 4, HB = 4, HA = 32, HF = 4;
    localparam int VS = 2, VB = 2, VA = 16, VF = 1;
    localparam int HT    = HS + HB + HA + HF;   // 44
    localparam int VT    = VS + VB + VA + VF;   // 21
    localparam int FRAME = HT * VT;             // 924
    localparam int CL    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [7:0] solid_color;
    logic       hsync, vsync, de, frame_start;
    logic [2:0] r, g;
    logic [1:0] b;
    logic [4:0] pix_x;
    logic [3:0] pix_y;
    logic [7:0] frame_cnt;

    vga_pattern_gen #(
        .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
        .CHECK_LOG2(CL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .solid_color(solid_color),
        .hsync(hsync), .vsync(vsync), .de(de),
        .r(r), .g(g), .b(b),
        .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         k        = 0;      // raster cycles since reset release
    int         epoch    = 0;      // 1 after the mid-frame reset
    logic [1:0] lmode    = 2'd0;   // model's frame-latched mode
    logic [7:0] lsolid   = 8'd0;
    bit         tally_ok = 1'b0;
    int         t_len, t_de, t_hs, t_vs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // One clock: capture the inputs the DUT sees at this edge, then compare
    // the outputs against the model.
    task automatic cycle();
        bit         in_rst, act;
        logic [1:0] in_mode;
        logic [7:0] in_solid, word, rgbv;
        int         pos, h, v, x, y, f, fr, hb, vb;
        logic       e_hs, e_vs, e_de, e_fs;
        logic [7:0] e_rgb, e_fc;
        int         e_x, e_y;

        @(posedge clk);
        in_rst   = !rst_n;
        in_mode  = mode;
        in_solid = solid_color;
        #1;
        act = 1'b0; x = 0; y = 0; f = 0; fr = 0;
        if (in_rst) begin
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = 8'd0;
            e_x = 0; e_y = 0; e_fs = 1'b0; e_fc = 8'd0;
            k = 0; lmode = 2'd0; lsolid = 8'd0; tally_ok = 1'b0;
        end else begin
            pos = k % FRAME;
            h   = pos % HT;
            v   = pos / HT;
            fr  = k / FRAME;
            f   = fr % 256;
            if (pos == 0) begin
                lmode  = in_mode;
                lsolid = in_solid;
            end
            act = (h >= HS + HB) && (h < HT - HF) && (v >= VS + VB) && (v < VT - VF);
            x = act ? h - (HS + HB) : 0;
            y = act ? v - (VS + VB) : 0;
            hb = (x / (HA / 16) > 15) ? 15 : x / (HA / 16);
            vb = (y / (VA / 16) > 15) ? 15 : y / (VA / 16);
            case (lmode)
                2'd0:    word = 8'((hb << 4) | vb);
                2'd1:    word = (((x >> CL) ^ (y >> CL)) & 1) != 0 ? 8'hFF : 8'h00;
                2'd2:    word = 8'(x + y + f);
                default: word = lsolid;
            endcase
            e_hs  = (h < HS) ? 1'b0 : 1'b1;
            e_vs  = (v < VS) ? 1'b0 : 1'b1;
            e_de  = act;
            e_rgb = act ? word : 8'd0;
            e_x   = x;
            e_y   = y;
            e_fs  = (pos == 0);
            e_fc  = 8'(f);
            k++;
        end

        rgbv = {r, g, b};
        check("hsync",       32'(hsync),       32'(e_hs));
        check("vsync",       32'(vsync),       32'(e_vs));
        check("de",          32'(de),          32'(e_de));
        check("rgb",         32'(rgbv),        32'(e_rgb));
        check("pix_x",       32'(pix_x),       32'(e_x));
        check("pix_y",       32'(pix_y),       32'(e_y));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("frame_cnt",   32'(frame_cnt),   32'(e_fc));

        // Directed corner pixels with fixed expected words
        if (act && lmode == 2'd0 && x == 5  && y == 3)  check("bars_5_3",   32'(rgbv), 32'h23);
        if (act && lmode == 2'd0 && x == 31 && y == 15) check("bars_31_15", 32'(rgbv), 32'hFF);
        if (act && lmode == 2'd1 && x == 0  && y == 0)  check("chk_0_0",    32'(rgbv), 32'h00);
        if (act && lmode == 2'd1 && x == 4  && y == 0)  check("chk_4_0",    32'(rgbv), 32'hFF);
        if (act && lmode == 2'd1 && x == 4  && y == 4)  check("chk_4_4",    32'(rgbv), 32'h00);
        if (act && epoch == 0 && fr == 1)               check("solid_f1",   32'(rgbv), 32'hA5);
        if (act && lmode == 2'd2 && f == 3 && x == 1 && y == 2) check("grad_1_2", 32'(rgbv), 32'h06);

        // Whole-frame tallies of the DUT's own outputs
        if (!in_rst) begin
            if (frame_start) begin
                if (tally_ok) begin
                    check("frame_len",  32'(t_len), 32'(FRAME));
                    check("de_count",   32'(t_de),  32'(HA * VA));
                    check("hsync_low",  32'(t_hs),  32'(HS * VT));
                    check("vsync_low",  32'(t_vs),  32'(VS * HT));
                end
                t_len = 0; t_de = 0; t_hs = 0; t_vs = 0;
                tally_ok = 1'b1;
            end
            t_len++;
            t_de += int'(de);
            t_hs += int'(!hsync);
            t_vs += int'(!vsync);
        end
    endtask

    initial begin
        int pos, fr, post;
        rst_n       = 1'b0;
        mode        = 2'd0;
        solid_color = 8'd0;
        post        = 0;
        t_len = 0; t_de = 0; t_hs = 0; t_vs = 0;

        repeat (5) cycle();
        rst_n = 1'b1;

        for (int n = 0; n < 8000; n++) begin
            cycle();
            if (!rst_n) begin
                rst_n = 1'b1;
                epoch = 1;
            end
            pos = k % FRAME;   // position the next edge will present
            fr  = k / FRAME;
            if (epoch == 0) begin
                if (fr >= 2 && pos < 900 && $urandom_range(0, 99) == 0) begin
                    mode        = 2'($urandom_range(0, 3));
                    solid_color = 8'($urandom);
                end
                if (fr == 0 && pos == (VS + VB + 5) * HT + 20) begin
                    mode        = 2'd3;
                    solid_color = 8'hA5;
                end
                if (fr == 1 && pos == 900) mode = 2'd1;
                if (fr == 2 && pos == 900) begin
                    mode        = 2'd2;
                    solid_color = 8'($urandom);
                end
                if (fr == 3 && pos == (VS + VB + 7) * HT + 20) rst_n = 1'b0;
            end else begin
                if ($urandom_range(0, 99) == 0) begin
                    mode        = 2'($urandom_range(0, 3));
                    solid_color = 8'($urandom);
                end
                post++;
                if (post > 2 * FRAME + 50) break;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  H_SYNC, 128, hsync pulse width (clocks)
  H_BP, 128, horizontal back porch
  H_ACTIVE, 800, visible pixels per line (>=16)
  H_FP, 32, horizontal front porch
  V_SYNC, 4, vsync pulse width (lines)
  V_BP, 14, vertical back porch
  V_ACTIVE, 600, visible lines (>=16)
  V_FP, 1, vertical front porch
  HSYNC_POL, 0, hsync active level
  VSYNC_POL, 0, vsync active level
  RW / GW / BW, 3 / 3 / 2, red / green / blue widths; CW = RW+GW+BW
  CHECK_LOG2, 5, checkerboard square size = 2**CHECK_LOG2
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
  clk  in  1  pixel clock
  rst_n  in  1  reset; one clock, reset synchronous active-low
  mode  in  2  pattern select: 0 bars, 1 checker, 2 gradient, 3 solid
  solid_color  in  CW  colour word for mode 3
  hsync  out  1  horizontal sync
  vsync  out  1  vertical sync
  de  out  1  active-video flag
  r / g / b  out  RW / GW / BW  colour
  pix_x  out  clog2(H_ACTIVE)  active column
  pix_y  out  clog2(V_ACTIVE)  active row
  frame_start  out  1  one-cycle pulse, first clock of each frame
  frame_cnt  out  8  completed-frame counter

Function
REQ-003 SHALL keep hctr 0..H_TOTAL-1 (H_TOTAL = sum of H params); at H_TOTAL-1 it SHALL wrap to 0 and advance vctr 0..V_TOTAL-1, which wraps to 0.
REQ-004 Line order SHALL be sync, back porch, active, front porch. Active: H_SYNC+H_BP <= hctr < H_TOTAL-H_FP. Same rule for vctr.
REQ-005 hsync SHALL be HSYNC_POL when hctr < H_SYNC, else ~HSYNC_POL. vsync SHALL follow the same rule with vctr and VSYNC_POL.
REQ-006 All outputs SHALL be registered with one clock latency from counter state, mutually aligned.
REQ-007 Outside the active area: de=0, r=g=b=0, pix_x=pix_y=0.
REQ-008 Inside the active area: de=1, pix_x = hctr-(H_SYNC+H_BP), pix_y = vctr-(V_SYNC+V_BP).
REQ-009 mode and solid_color SHALL be latched only when the counters are at (0,0). Mid-frame changes SHALL take effect the next frame.
REQ-010 The colour word SHALL map MSB-first onto {r,g,b}.
REQ-011 Mode 0 (bars):
  - Word = {hb[3:0], vb[3:0]}, zero-extended or truncated to CW.
  - hb = horizontal band index, from a band counter stepping every H_ACTIVE/16 pixels (floor), saturating at 15, reset at the start of each line.
  - vb = the same rule per line over V_ACTIVE; no divider.
REQ-012 Mode 1 (checker): word = all ones if pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2], else 0.
REQ-013 Mode 2 (gradient): word = (pix_x + pix_y + frame_cnt) mod 2**CW.
REQ-014 Mode 3 (solid): word = latched solid_color.
REQ-015 frame_cnt SHALL increment when the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0), and wrap 255->0.
REQ-016 frame_start SHALL be 1 exactly in the output cycle that reflects counter state (0,0).

Reset
REQ-017 While rst_n=0 at a clk edge, the block SHALL load:
  - counters = 0, latched mode = 0, latched colour = 0, frame_cnt = 0, band counters = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
  - de = 0, rgb = 0, pix_x = pix_y = 0, frame_start = 0
REQ-018 Reset asserted mid-frame SHALL abort the frame. The first edge after release SHALL show state (0,0): frame_start=1, hsync=HSYNC_POL, vsync=VSYNC_POL.

Verification (small config: H 4/4/32/4 -> H_TOTAL 44; V 2/2/16/1 -> V_TOTAL 21; frame 924 clocks; CHECK_LOG2=2; default polarity and widths)
REQ-019 Reset: rst_n low for 5 clocks -> hsync=1, vsync=1, de=0, rgb=0, frame_cnt=0. First clock after release -> frame_start=1, hsync=0, vsync=0.
REQ-020 Timing over 2 frames:
  - hsync low 4 of every 44 clocks.
  - de high 32 clocks per line on 16 lines.
  - vsync low for 88 clocks.
  - frame_start every 924 clocks.
  - frame_cnt 0->1->2.
REQ-021 Bars, mode 0: pixel (5,3) -> word 8'h23 (r=001, g=000, b=11). Pixel (31,15) -> 8'hFF.
REQ-022 Checker, mode 1:
  - (0,0) -> r=g=b=0
  - (4,0) -> r=111, g=111, b=11
  - (4,4) -> 0
REQ-023 Mode latch: in frame 0, switch mode 0->3 with solid_color=8'hA5 at pix_y=5. Rest of frame 0 stays bars. Frame 1: every active pixel r=101, g=001, b=01.
REQ-024 Gradient and reset mid-frame:
  - Mode 2, frame_cnt=3, pixel (1,2) -> word 8'h06.
  - Pulse rst_n low at pix_y=7 -> outputs take reset values next clock, frame_cnt=0, frame restarts with frame_start.
